dpram_be_param: RTL and testbench
=================================

Name: dpram_be_param

Overview:
- Parametrised true dual-port block RAM on a single clock. Generalises the fixed 2048x8 program-memory BRAM.
- Adds configurable width and depth, per-byte write enables, and an optional output pipeline register.
- Adds per-port valid flags, a selectable write mode, and a same-address collision policy.
- Adds an optional post-reset zero-fill sequencer.
- Used as program/data memory for the RiscY core and as scratch memory for the RVV unit. Port A faces the core; port B faces the loader or vector unit.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of BYTE_W.
- ADDR_W, 11, address width; depth = 2**ADDR_W words.
- BYTE_W, 8, bits per byte lane; NB = DATA_W/BYTE_W.
- OUT_REG, 0, 0 = read latency 1 (bypass); 1 = read latency 2 (output register gated by oce).
- WRITE_MODE, 0, 0 = no-change, 1 = write-through, 2 = read-before-write. Applies to both ports.
- CLEAR_ON_RESET, 1, 1 = zero-fill the entire array after reset release.

Ports:
- clk  in  1  single clock for both ports
- resetn  in  1  asynchronous active-low reset
- busy  out  1  zero-fill in progress; all port requests are ignored while high
- a_ce  in  1  port A access enable
- a_we  in  1  port A write (1) / read (0)
- a_be  in  NB  port A byte enables; used only when a_we=1
- a_addr  in  ADDR_W  port A word address
- a_din  in  DATA_W  port A write data
- a_oce  in  1  port A output-register enable; used only when OUT_REG=1
- a_dout  out  DATA_W  port A read data
- a_valid  out  1  a_dout updated this cycle with a read result
- b_ce, b_we, b_be, b_addr, b_din, b_oce, b_dout, b_valid: same as port A, for port B
- collision  out  1  one-cycle pulse on any same-address conflict

Behaviour:
- Reset (resetn=0, asynchronous):
  - a_dout, b_dout, a_valid, b_valid, collision clear to 0.
  - Internal pipeline registers and the sweep counter clear to 0.
  - busy = CLEAR_ON_RESET.
  - Array contents are not touched by reset itself.
- Sequencer: states CLEAR and READY.
  - After reset release the block enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - CLEAR writes zero to address cnt each cycle, for cnt = 0 .. 2**ADDR_W-1.
  - After the last address, busy drops on the next edge and the state becomes READY. CLEAR therefore lasts exactly 2**ADDR_W cycles with busy high.
  - Reset asserted mid-sweep restarts the sweep from address 0.
  - ce inputs are ignored in CLEAR, and valid flags stay 0.
- Write (ce=1, we=1, state READY):
  - Byte lane i of mem[addr] is updated on the clock edge when be[i]=1; other lanes are unchanged.
  - be = 0 is a legal no-op write.
- Read (ce=1, we=0):
  - OUT_REG=0: dout = mem[addr] one edge later; valid pulses in that cycle.
  - OUT_REG=1: the stage-1 result moves to dout at the next edge where oce=1; valid pulses when that transfer happens.
  - With oce=0, the stage-2 register holds. A newer stage-1 result overwrites the pending one, and that lost read is not flagged.
  - When no read occurs, dout holds its last value.
- Write-port dout, selected by WRITE_MODE:
  - 0: dout unchanged and valid=0.
  - 1: dout = merged new word and valid=1.
  - 2: dout = old word and valid=1.
  - This dout passes through the OUT_REG stage like a read.
- Collisions (same address, same cycle, both ce=1):
  - Both ports write: port A's enabled lanes win; port B's lanes apply only where A's be=0. collision=1.
  - One port writes, the other reads: the reader returns the old word. collision=1.
  - Both ports read: no collision.
- Timing: no combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package dpram_pkg holds:
  - the write-mode constants WM_NO_CHANGE=0, WM_WRITE_THROUGH=1, WM_READ_FIRST=2;
  - the sequencer state enum {CLEAR, READY};
  - a function computing NB.
- One sub-module, dpram_port_pipe, instantiated once per port. It holds the stage-1/stage-2 data registers, valid generation, and oce gating.
- The array, byte-merge, collision logic, and sequencer stay in the top level.

Test Plan (DATA_W=32, ADDR_W=4, BYTE_W=8 unless noted):
- Zero-fill: release reset with CLEAR_ON_RESET=1 -> busy high for exactly 16 cycles. Reading all 16 addresses then returns 0x00000000. Asserting reset at sweep cycle 7 restarts the 16-cycle count.
- Byte enables: A writes 0xAABBCCDD to address 3 with be=1111, then 0x11223344 with be=0101 -> B reads address 3 one cycle later (OUT_REG=0) and gets 0xAA22CC44 with b_valid=1.
- Latency/oce (OUT_REG=1): read address 3 with a_oce=1 -> data appears 2 cycles later. Holding a_oce=0 for 3 cycles -> a_dout holds and a_valid stays 0 until oce=1.
- Write modes: address 5 holds 0x12345678; A writes 0xCAFEF00D. WRITE_MODE=0 -> a_valid=0, a_dout unchanged. WRITE_MODE=1 -> a_dout=0xCAFEF00D. WRITE_MODE=2 -> a_dout=0x12345678.
- Collision: A writes 0x000000FF with be=0001 and B writes 0xFFFFFF00 with be=1111 to address 9 in the same cycle -> collision=1 for 1 cycle; a later read of address 9 returns 0xFFFFFFFF.
- Read/write conflict: address 2 holds 0x0; B reads address 2 while A writes 0x5A5A5A5A to it -> b_dout=0x00000000 and collision=1; the next B read returns 0x5A5A5A5A.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared constants, sequencer state type and sizing helper for the
// parametrised dual-port byte-enable RAM.
package dpram_pkg;

    localparam int WM_NO_CHANGE     = 0;
    localparam int WM_WRITE_THROUGH = 1;
    localparam int WM_READ_FIRST    = 2;

    typedef enum logic {
        CLEAR,
        READY
    } seq_state_t;

    function automatic int calc_nb(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/dpram_port_pipe.sv
// Per-port read pipeline: stage-1 capture, optional oce-gated output
// register and the matching valid pulse.
module dpram_port_pipe
    import dpram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OUT_REG = 0
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              ld,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              oce,
    output logic [DATA_W-1:0] dout,
    output logic              valid
);

    logic [DATA_W-1:0] s1_q;
    logic              pend_q;
    logic              xfer;
    logic [DATA_W-1:0] xfer_data;

    // Without the output register, the array word goes straight to dout;
    // the stage-1 flops are then dead and get trimmed.
    always_comb begin
        xfer      = ld;
        xfer_data = ld_data;
        if (OUT_REG != 0) begin
            xfer      = oce && pend_q;
            xfer_data = s1_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q   <= '0;
            pend_q <= 1'b0;
            dout   <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= xfer;
            if (xfer) begin
                dout <= xfer_data;
            end
            // A new result replaces an unconsumed one silently.
            if (ld) begin
                s1_q   <= ld_data;
                pend_q <= 1'b1;
            end else if (xfer) begin
                pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dpram_be_param.sv
// True dual-port single-clock RAM with byte enables, selectable write mode,
// same-address collision policy and optional post-reset zero fill.
module dpram_be_param
    import dpram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 11,
    parameter int BYTE_W         = 8,
    parameter int OUT_REG        = 0,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NB            = calc_nb(DATA_W, BYTE_W)
)(
    input  logic              clk,
    input  logic              resetn,
    output logic              busy,
    input  logic              a_ce,
    input  logic              a_we,
    input  logic [NB-1:0]     a_be,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    input  logic              a_oce,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_valid,
    input  logic              b_ce,
    input  logic              b_we,
    input  logic [NB-1:0]     b_be,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    input  logic              b_oce,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_valid,
    output logic              collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              a_wr, b_wr, same_addr;
    logic              a_ld, b_ld, coll_d;
    logic [DATA_W-1:0] a_old, b_old, a_new, b_new, a_word, b_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == '1) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt_q   <= '0;
            busy    <= (CLEAR_ON_RESET != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d == CLEAR);
        end
    end

    // a_new/b_new are the words each address holds after this edge, with
    // port A's enabled lanes taking priority over port B's on a shared address.
    always_comb begin
        ready     = (state_q == READY);
        a_wr      = ready && a_ce && a_we;
        b_wr      = ready && b_ce && b_we;
        same_addr = (a_addr == b_addr);
        a_old     = mem[a_addr];
        b_old     = mem[b_addr];
        a_new     = a_old;
        b_new     = b_old;
        for (int unsigned i = 0; i < NB; i++) begin
            if (a_wr && a_be[i]) begin
                a_new[i*BYTE_W +: BYTE_W] = a_din[i*BYTE_W +: BYTE_W];
            end else if (b_wr && same_addr && b_be[i]) begin
                a_new[i*BYTE_W +: BYTE_W] = b_din[i*BYTE_W +: BYTE_W];
            end
            if (a_wr && same_addr && a_be[i]) begin
                b_new[i*BYTE_W +: BYTE_W] = a_din[i*BYTE_W +: BYTE_W];
            end else if (b_wr && b_be[i]) begin
                b_new[i*BYTE_W +: BYTE_W] = b_din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        a_ld   = ready && a_ce && (!a_we || (WRITE_MODE != WM_NO_CHANGE));
        b_ld   = ready && b_ce && (!b_we || (WRITE_MODE != WM_NO_CHANGE));
        a_word = (a_we && (WRITE_MODE == WM_WRITE_THROUGH)) ? a_new : a_old;
        b_word = (b_we && (WRITE_MODE == WM_WRITE_THROUGH)) ? b_new : b_old;
        coll_d = ready && a_ce && b_ce && same_addr && (a_we || b_we);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            if (state_q == CLEAR) begin
                mem[cnt_q] <= '0;
            end else begin
                if (b_wr) begin
                    mem[b_addr] <= b_new;
                end
                if (a_wr) begin
                    mem[a_addr] <= a_new;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            collision <= 1'b0;
        end else begin
            collision <= coll_d;
        end
    end

    dpram_port_pipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_pipe_a (
        .clk     (clk),
        .resetn  (resetn),
        .ld      (a_ld),
        .ld_data (a_word),
        .oce     (a_oce),
        .dout    (a_dout),
        .valid   (a_valid)
    );

    dpram_port_pipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_pipe_b (
        .clk     (clk),
        .resetn  (resetn),
        .ld      (b_ld),
        .ld_data (b_word),
        .oce     (b_oce),
        .dout    (b_dout),
        .valid   (b_valid)
    );

endmodule

// File: tb/tb_dpram_be_param.sv
// Three configurations of dpram_be_param driven in lockstep and checked every
// cycle against a word-level reference model, plus literal directed checks.
module tb_dpram_be_param;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        ce_i   [2];
    logic        we_i   [2];
    logic        oce_i  [2];
    logic [3:0]  be_i   [2];
    logic [3:0]  addr_i [2];
    logic [31:0] din_i  [2];

    logic [31:0] dout_w  [3][2];
    logic        valid_w [3][2];
    logic        coll_w  [3];
    logic        busy_w  [3];

    // d0: latency 1, write-through; d1: latency 2, read-first; d2: latency 1, no-change
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int ORK = (k == 1) ? 1 : 0;
        localparam int WMK = (k == 0) ? 1 : ((k == 1) ? 2 : 0);
        dpram_be_param #(
            .DATA_W         (32),
            .ADDR_W         (4),
            .BYTE_W         (8),
            .OUT_REG        (ORK),
            .WRITE_MODE     (WMK),
            .CLEAR_ON_RESET (1)
        ) u_dut (
            .clk       (clk),
            .resetn    (resetn),
            .busy      (busy_w[k]),
            .a_ce      (ce_i[0]),
            .a_we      (we_i[0]),
            .a_be      (be_i[0]),
            .a_addr    (addr_i[0]),
            .a_din     (din_i[0]),
            .a_oce     (oce_i[0]),
            .a_dout    (dout_w[k][0]),
            .a_valid   (valid_w[k][0]),
            .b_ce      (ce_i[1]),
            .b_we      (we_i[1]),
            .b_be      (be_i[1]),
            .b_addr    (addr_i[1]),
            .b_din     (din_i[1]),
            .b_oce     (oce_i[1]),
            .b_dout    (dout_w[k][1]),
            .b_valid   (valid_w[k][1]),
            .collision (coll_w[k])
        );
    end

    int checks = 0;
    int errors = 0;

    logic [31:0] mm [16];
    logic [31:0] e_dout  [3][2];
    logic [31:0] s1      [3][2];
    logic        e_valid [3][2];
    logic        pend    [3][2];
    logic        e_coll;
    logic        m_busy;
    logic [3:0]  m_cnt;

    function automatic int or_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic int wm_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 0);
    endfunction

    function automatic string pn(input int p);
        return (p == 0) ? "a" : "b";
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b1;
        m_cnt  = '0;
        e_coll = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                e_dout[k][p]  = '0;
                e_valid[k][p] = 1'b0;
                s1[k][p]      = '0;
                pend[k][p]    = 1'b0;
            end
        end
    endtask

    // Effect of one clock edge, using the inputs presented before it.
    task automatic model_edge();
        logic [31:0] oldw [2];
        logic [31:0] fin  [2];
        logic [31:0] word;
        logic        ld, xfer, ready;
        ready = !m_busy;
        for (int p = 0; p < 2; p++) oldw[p] = mm[addr_i[p]];
        if (!ready) begin
            mm[m_cnt] = '0;
            if (m_cnt == 4'd15) m_busy = 1'b0;
            m_cnt  = m_cnt + 4'd1;
            e_coll = 1'b0;
        end else begin
            // port B first so that port A's lanes override on a shared address
            for (int p = 1; p >= 0; p--) begin
                if (ce_i[p] && we_i[p]) begin
                    for (int l = 0; l < 4; l++) begin
                        if (be_i[p][l]) mm[addr_i[p]][8*l +: 8] = din_i[p][8*l +: 8];
                    end
                end
            end
            e_coll = ce_i[0] && ce_i[1] && (addr_i[0] == addr_i[1]) && (we_i[0] || we_i[1]);
        end
        for (int p = 0; p < 2; p++) fin[p] = mm[addr_i[p]];
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                ld   = ready && ce_i[p] && (!we_i[p] || wm_of(k) != 0);
                word = (we_i[p] && wm_of(k) == 1) ? fin[p] : oldw[p];
                if (or_of(k) == 0) begin
                    if (ld) e_dout[k][p] = word;
                    e_valid[k][p] = ld;
                end else begin
                    xfer = oce_i[p] && pend[k][p];
                    e_valid[k][p] = xfer;
                    if (xfer) e_dout[k][p] = s1[k][p];
                    if (ld) begin
                        s1[k][p]   = word;
                        pend[k][p] = 1'b1;
                    end else if (xfer) begin
                        pend[k][p] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("d%0d_%s_dout", k, pn(p)), dout_w[k][p], e_dout[k][p]);
                chk($sformatf("d%0d_%s_valid", k, pn(p)), 32'(valid_w[k][p]), 32'(e_valid[k][p]));
            end
            chk($sformatf("d%0d_collision", k), 32'(coll_w[k]), 32'(e_coll));
            chk($sformatf("d%0d_busy", k), 32'(busy_w[k]), 32'(m_busy));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #2;
        model_reset();
        compare_all();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic set_port(input int p, input logic ce, input logic we, input logic [3:0] be,
                            input logic [3:0] addr, input logic [31:0] din);
        ce_i[p]   = ce;
        we_i[p]   = we;
        be_i[p]   = be;
        addr_i[p] = addr;
        din_i[p]  = din;
    endtask

    task automatic idle();
        set_port(0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        oce_i[0] = 1'b1;
        oce_i[1] = 1'b1;
    endtask

    task automatic rand_inputs();
        for (int p = 0; p < 2; p++) begin
            ce_i[p]   = ($urandom_range(0, 9) < 7);
            we_i[p]   = 1'($urandom_range(0, 1));
            be_i[p]   = 4'($urandom_range(0, 15));
            addr_i[p] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 3));
            din_i[p]  = $urandom;
            oce_i[p]  = ($urandom_range(0, 9) < 6);
        end
    endtask

    task automatic count_busy(input int limit, output int n);
        n = 0;
        do begin
            rand_inputs();
            cyc();
            n++;
        end while (busy_w[0] && n < limit);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mm[i] = '0;
        idle();
        resetn = 1'b1;
        #1;
        do_reset();
        chk("reset_busy", 32'(busy_w[0]), 32'h1);
        chk("reset_a_dout", dout_w[0][0], 32'h0);

        count_busy(100, n);
        chk("clear_len", 32'(n), 32'd16);

        // every address reads back as zero after the sweep
        for (int i = 0; i < 16; i++) begin
            set_port(0, 1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
            set_port(1, 1'b1, 1'b0, 4'h0, 4'(15 - i), 32'h0);
            cyc();
            chk("zero_fill_a", dout_w[0][0], 32'h0);
        end
        idle();
        cyc();

        // byte-enable merge
        set_port(0, 1'b1, 1'b1, 4'hF, 4'd3, 32'hAABBCCDD);
        cyc();
        set_port(0, 1'b1, 1'b1, 4'h5, 4'd3, 32'h11223344);
        cyc();
        idle();
        set_port(1, 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        cyc();
        chk("be_merge_b_dout", dout_w[0][1], 32'hAA22CC44);
        chk("be_merge_b_valid", 32'(valid_w[0][1]), 32'h1);

        // write modes on address 5
        idle();
        set_port(0, 1'b1, 1'b1, 4'hF, 4'd5, 32'h12345678);
        cyc();
        set_port(0, 1'b1, 1'b1, 4'hF, 4'd5, 32'hCAFEF00D);
        cyc();
        chk("wm_through_dout", dout_w[0][0], 32'hCAFEF00D);
        chk("wm_through_valid", 32'(valid_w[0][0]), 32'h1);
        chk("wm_nochange_valid", 32'(valid_w[2][0]), 32'h0);
        idle();
        cyc();
        chk("wm_readfirst_dout", dout_w[1][0], 32'h12345678);
        chk("wm_readfirst_valid", 32'(valid_w[1][0]), 32'h1);

        // output register latency and oce hold
        set_port(0, 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        cyc();
        chk("lat2_first_valid", 32'(valid_w[1][0]), 32'h0);
        chk("lat1_dout", dout_w[0][0], 32'hAA22CC44);
        idle();
        cyc();
        chk("lat2_dout", dout_w[1][0], 32'hAA22CC44);
        chk("lat2_valid", 32'(valid_w[1][0]), 32'h1);
        set_port(0, 1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
        oce_i[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            idle();
            oce_i[0] = 1'b0;
            chk("oce_hold_dout", dout_w[1][0], 32'hAA22CC44);
            chk("oce_hold_valid", 32'(valid_w[1][0]), 32'h0);
        end
        idle();
        cyc();
        chk("oce_release_dout", dout_w[1][0], 32'hCAFEF00D);
        chk("oce_release_valid", 32'(valid_w[1][0]), 32'h1);

        // write/write collision
        set_port(0, 1'b1, 1'b1, 4'h1, 4'd9, 32'h000000FF);
        set_port(1, 1'b1, 1'b1, 4'hF, 4'd9, 32'hFFFFFF00);
        cyc();
        chk("ww_collision", 32'(coll_w[0]), 32'h1);
        idle();
        cyc();
        chk("ww_collision_pulse", 32'(coll_w[0]), 32'h0);
        set_port(0, 1'b1, 1'b0, 4'h0, 4'd9, 32'h0);
        cyc();
        chk("ww_result", dout_w[0][0], 32'hFFFFFFFF);

        // read/write conflict
        idle();
        set_port(0, 1'b1, 1'b1, 4'hF, 4'd2, 32'h5A5A5A5A);
        set_port(1, 1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
        cyc();
        chk("rw_old_word", dout_w[0][1], 32'h00000000);
        chk("rw_collision", 32'(coll_w[0]), 32'h1);
        idle();
        set_port(1, 1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
        cyc();
        chk("rw_new_word", dout_w[0][1], 32'h5A5A5A5A);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cyc();
        end

        // reset part-way through the sweep restarts it
        do_reset();
        for (int i = 0; i < 7; i++) begin
            rand_inputs();
            cyc();
        end
        chk("mid_sweep_busy", 32'(busy_w[0]), 32'h1);
        do_reset();
        count_busy(100, n);
        chk("restart_len", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            set_port(0, 1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
            set_port(1, 1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
            cyc();
            chk("refill_b", dout_w[0][1], 32'h0);
        end
        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
